// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one 32-bit logical shifter.
// Each operation is grant -> shift -> hold result until the consumer takes it.
module shift32 (
    input  logic [31:0] d,
    input  logic [31:0] s,
    input  logic        lnr,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        // any amount with upper bits set is a full shift-out
        if (s[31:5] == 27'd0) begin
            y = lnr ? (d << s[4:0]) : (d >> s[4:0]);
        end
    end
endmodule

// state | meaning
// IDLE  | accepting requests; READY may be asserted for the granted requester
// SHIFT | operands captured; shifter output is loaded into the result register
// DONE  | result held on RES_* until RES_READY
module shift_arbiter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VALID,
    input  logic                 REQ1_VALID,
    output logic                 REQ0_READY,
    output logic                 REQ1_READY,
    input  logic [31:0]          REQ0_D,
    input  logic [31:0]          REQ1_D,
    input  logic [31:0]          REQ0_S,
    input  logic [31:0]          REQ1_S,
    input  logic                 REQ0_LNR,
    input  logic                 REQ1_LNR,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [31:0]          RES_Y,
    output logic                 RES_ID,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] OP_COUNT
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            op_d_q, op_d_d;
    logic [31:0]            op_s_q, op_s_d;
    logic                   op_lnr_q, op_lnr_d;
    logic                   op_id_q, op_id_d;
    logic                   last_id_q, last_id_d;
    logic                   res_valid_q, res_valid_d;
    logic [31:0]            res_y_q, res_y_d;
    logic                   res_id_q, res_id_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            shift_y;
    logic                   gnt0, gnt1;

    shift32 u_shift32 (
        .d   (op_d_q),
        .s   (op_s_q),
        .lnr (op_lnr_q),
        .y   (shift_y)
    );

    // a tie goes to whoever did not win last time
    assign gnt0 = REQ0_VALID && (!REQ1_VALID || last_id_q);
    assign gnt1 = REQ1_VALID && (!REQ0_VALID || !last_id_q);

    always_comb begin
        state_d     = state_q;
        op_d_d      = op_d_q;
        op_s_d      = op_s_q;
        op_lnr_d    = op_lnr_q;
        op_id_d     = op_id_q;
        last_id_d   = last_id_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_id_d    = res_id_q;
        cnt_d       = cnt_q;
        REQ0_READY  = 1'b0;
        REQ1_READY  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!RST && gnt0) begin
                    REQ0_READY = 1'b1;
                    op_d_d     = REQ0_D;
                    op_s_d     = REQ0_S;
                    op_lnr_d   = REQ0_LNR;
                    op_id_d    = 1'b0;
                    last_id_d  = 1'b0;
                    state_d    = S_SHIFT;
                end else if (!RST && gnt1) begin
                    REQ1_READY = 1'b1;
                    op_d_d     = REQ1_D;
                    op_s_d     = REQ1_S;
                    op_lnr_d   = REQ1_LNR;
                    op_id_d    = 1'b1;
                    last_id_d  = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_y_d     = shift_y;
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    cnt_d       = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_d_q      <= '0;
            op_s_q      <= '0;
            op_lnr_q    <= 1'b0;
            op_id_q     <= 1'b0;
            last_id_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_id_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_d_q      <= op_d_d;
            op_s_q      <= op_s_d;
            op_lnr_q    <= op_lnr_d;
            op_id_q     <= op_id_d;
            last_id_q   <= last_id_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_id_q    <= res_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign RES_VALID = res_valid_q;
    assign RES_Y     = res_y_q;
    assign RES_ID    = res_id_q;
    assign BUSY      = (state_q != S_IDLE);
    assign OP_COUNT  = cnt_q;
endmodule
